// File: rtl/wasd_key_filter_pkg.sv
// Shared key codes, key FSM state encoding and axis winner encoding for the
// WASD key filter.
package key_pkg;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, REL_PEND} key_state_t;

  typedef enum logic [1:0] {NONE, NEG, POS} axis_t;

  function automatic logic key_present(input logic [15:0] kc, input logic [7:0] code);
    return (kc[15:8] == code) || (kc[7:0] == code);
  endfunction

endpackage

// File: rtl/wasd_key_filter_if.sv
// Frame-rate keyboard input and filtered motion output bundle.
interface wasd_key_filter_if;
  logic        frame_tick;
  logic [15:0] keycode;
  logic [15:0] keycode_out;
  logic [9:0]  x_motion;
  logic [9:0]  y_motion;
  logic        motion_upd;
  logic [3:0]  key_held;

  modport master (
    output frame_tick, keycode,
    input  keycode_out, x_motion, y_motion, motion_upd, key_held
  );

  modport slave (
    input  frame_tick, keycode,
    output keycode_out, x_motion, y_motion, motion_upd, key_held
  );
endinterface

// File: rtl/wasd_key_filter_key_debounce.sv
// Per-key frame-tick debouncer. held_nxt/rise look one edge ahead so the top
// level can register its outputs on the same edge as the FSM.
//
// state      | meaning
// IDLE       | key released and stable
// PRESS_PEND | key seen present, counting toward acceptance
// HELD       | key accepted as pressed
// REL_PEND   | key seen absent, counting toward release
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic tick,
  input  logic present,
  output logic held,
  output logic held_nxt,
  output logic rise
);

  localparam logic [1:0] DF = 2'(DEBOUNCE_FRAMES);

  key_state_t state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [1:0] cnt_inc;

  assign cnt_inc = cnt + 2'd1;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise      = 1'b0;
    if (tick) begin
      case (state)
        IDLE: if (present) begin
          if (DF == 2'd1) begin
            state_nxt = HELD;
            rise      = 1'b1;
          end else begin
            state_nxt = PRESS_PEND;
            cnt_nxt   = 2'd1;
          end
        end
        PRESS_PEND: if (present) begin
          if (cnt_inc == DF) begin
            state_nxt = HELD;
            cnt_nxt   = 2'd0;
            rise      = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = 2'd0;
        end
        HELD: if (!present) begin
          if (DF == 2'd1) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = REL_PEND;
            cnt_nxt   = 2'd1;
          end
        end
        REL_PEND: if (!present) begin
          if (cnt_inc == DF) begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else begin
          // a bounce back to present is not a fresh press, so no rise
          state_nxt = HELD;
          cnt_nxt   = 2'd0;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  assign held     = (state == HELD) || (state == REL_PEND);
  assign held_nxt = (state_nxt == HELD) || (state_nxt == REL_PEND);

endmodule

// File: rtl/wasd_key_filter.sv
// WASD keyboard filter: debounces four keys at frame rate, arbitrates each
// opposing pair by most-recent press, and registers code/motion outputs.
module wasd_key_filter
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter logic [9:0]  STEP            = 10'd1
) (
  input logic               Clk,
  input logic               Reset_n,
  wasd_key_filter_if.slave  bus
);

  // index 3..0 = W, A, S, D
  logic [3:0] present, held, held_nxt, rise;
  axis_t      x_win, y_win, x_win_nxt, y_win_nxt;

  assign present = {key_present(bus.keycode, KEY_W), key_present(bus.keycode, KEY_A),
                    key_present(bus.keycode, KEY_S), key_present(bus.keycode, KEY_D)};

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .tick     (bus.frame_tick),
      .present  (present[i]),
      .held     (held[i]),
      .held_nxt (held_nxt[i]),
      .rise     (rise[i])
    );
  end

  // Simultaneous rise neutralises the axis; NONE then sticks while both stay held.
  function automatic axis_t arbitrate(input axis_t cur, input logic neg_h, input logic pos_h,
                                      input logic neg_r, input logic pos_r);
    if (neg_r && pos_r) return NONE;
    if (neg_r)          return NEG;
    if (pos_r)          return POS;
    if (neg_h && pos_h) return cur;
    if (neg_h)          return NEG;
    if (pos_h)          return POS;
    return NONE;
  endfunction

  function automatic logic [9:0] motion_of(input axis_t w);
    case (w)
      NEG:     return ~STEP + 10'd1;
      POS:     return STEP;
      default: return 10'd0;
    endcase
  endfunction

  function automatic logic [7:0] code_of(input axis_t w, input logic [7:0] neg_code,
                                         input logic [7:0] pos_code);
    case (w)
      NEG:     return neg_code;
      POS:     return pos_code;
      default: return 8'h00;
    endcase
  endfunction

  assign x_win_nxt = arbitrate(x_win, held_nxt[2], held_nxt[0], rise[2], rise[0]);
  assign y_win_nxt = arbitrate(y_win, held_nxt[3], held_nxt[1], rise[3], rise[1]);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      x_win           <= NONE;
      y_win           <= NONE;
      bus.keycode_out <= 16'h0000;
      bus.x_motion    <= 10'd0;
      bus.y_motion    <= 10'd0;
      bus.motion_upd  <= 1'b0;
      bus.key_held    <= 4'b0000;
    end else begin
      bus.motion_upd <= bus.frame_tick;
      if (bus.frame_tick) begin
        x_win           <= x_win_nxt;
        y_win           <= y_win_nxt;
        bus.keycode_out <= {code_of(x_win_nxt, KEY_A, KEY_D), code_of(y_win_nxt, KEY_W, KEY_S)};
        bus.x_motion    <= motion_of(x_win_nxt);
        bus.y_motion    <= motion_of(y_win_nxt);
        bus.key_held    <= held_nxt;
      end
    end
  end

endmodule

// File: tb/tb_wasd_key_filter.sv
// Scoreboard bench for wasd_key_filter with DEBOUNCE_FRAMES=2, STEP=1.
module tb_wasd_key_filter;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  wasd_key_filter_if bus ();

  wasd_key_filter #(.DEBOUNCE_FRAMES(2), .STEP(10'd1)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          id;
    logic [15:0] kc;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  h;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   tests = 0;
  int   fails = 0;
  int   tick_id = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_tick(input logic [15:0] kc, input logic [15:0] ekc,
                         input logic [9:0] ex, input logic [9:0] ey, input logic [3:0] eh);
    exp_t e;
    tick_id++;
    e.id = tick_id; e.kc = ekc; e.x = ex; e.y = ey; e.h = eh;
    sb.push_back(e);
    bus.keycode    = kc;
    bus.frame_tick = 1'b1;
    @(posedge Clk);
    #1;
    bus.frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic tk(input logic [15:0] kc, input logic [15:0] ekc,
                    input logic [9:0] ex, input logic [9:0] ey, input logic [3:0] eh);
    do_tick(kc, ekc, ex, ey, eh);
    idle(2);
  endtask

  // Monitor: every motion_upd pulse must match the oldest expected update.
  always @(negedge Clk) begin
    if (bus.motion_upd === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_upd: motion_upd with no tick outstanding, kc=%h x=%h y=%h",
                 bus.keycode_out, bus.x_motion, bus.y_motion);
      end else begin
        me = sb.pop_front();
        if ({bus.keycode_out, bus.x_motion, bus.y_motion, bus.key_held} !==
            {me.kc, me.x, me.y, me.h}) begin
          fails++;
          $display("FAIL tick%0d: got kc=%h x=%h y=%h held=%b, expected kc=%h x=%h y=%h held=%b",
                   me.id, bus.keycode_out, bus.x_motion, bus.y_motion, bus.key_held,
                   me.kc, me.x, me.y, me.h);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.keycode    = 16'h0000;
    bus.frame_tick = 1'b0;
    Reset_n        = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_kc",   32'(bus.keycode_out), 32'h0);
    chk("rst_x",    32'(bus.x_motion),    32'h0);
    chk("rst_y",    32'(bus.y_motion),    32'h0);
    chk("rst_held", 32'(bus.key_held),    32'h0);
    chk("rst_upd",  32'(bus.motion_upd),  32'h0);
    Reset_n = 1'b1;
    idle(1);

    // W press and release
    tk(16'h001A, 16'h0000, 10'h000, 10'h000, 4'b0000);
    tk(16'h001A, 16'h001A, 10'h000, 10'h3FF, 4'b1000);
    chk("hold_kc",  32'(bus.keycode_out), 32'h001A);
    chk("hold_upd", 32'(bus.motion_upd),  32'h0);
    tk(16'h0000, 16'h001A, 10'h000, 10'h3FF, 4'b1000);
    tk(16'h0000, 16'h0000, 10'h000, 10'h000, 4'b0000);

    // D glitch for one tick only
    tk(16'h0700, 16'h0000, 10'h000, 10'h000, 4'b0000);
    tk(16'h0000, 16'h0000, 10'h000, 10'h000, 4'b0000);
    tk(16'h0000, 16'h0000, 10'h000, 10'h000, 4'b0000);

    // D held, A added later wins, A released hands back to D
    tk(16'h0700, 16'h0000, 10'h000, 10'h000, 4'b0000);
    tk(16'h0700, 16'h0700, 10'h001, 10'h000, 4'b0001);
    tk(16'h0704, 16'h0700, 10'h001, 10'h000, 4'b0001);
    tk(16'h0704, 16'h0400, 10'h3FF, 10'h000, 4'b0101);
    tk(16'h0007, 16'h0400, 10'h3FF, 10'h000, 4'b0101);
    tk(16'h0007, 16'h0700, 10'h001, 10'h000, 4'b0001);
    tk(16'h0000, 16'h0700, 10'h001, 10'h000, 4'b0001);
    tk(16'h0000, 16'h0000, 10'h000, 10'h000, 4'b0000);

    // W+S same tick -> neutral; S release -> W; back-to-back ticks
    tk(16'h1A16, 16'h0000, 10'h000, 10'h000, 4'b0000);
    tk(16'h1A16, 16'h0000, 10'h000, 10'h000, 4'b1010);
    do_tick(16'h001A, 16'h0000, 10'h000, 10'h000, 4'b1010);
    do_tick(16'h001A, 16'h001A, 10'h000, 10'h3FF, 4'b1000);
    idle(2);
    tk(16'h0000, 16'h001A, 10'h000, 10'h3FF, 4'b1000);
    tk(16'h0000, 16'h0000, 10'h000, 10'h000, 4'b0000);

    // Off-tick keycode change is ignored
    bus.keycode = 16'h0007;
    idle(3);
    tk(16'h0000, 16'h0000, 10'h000, 10'h000, 4'b0000);
    tk(16'h0000, 16'h0000, 10'h000, 10'h000, 4'b0000);

    // A+S held, then reset coincident with a tick
    tk(16'h0416, 16'h0000, 10'h000, 10'h000, 4'b0000);
    tk(16'h0416, 16'h0416, 10'h3FF, 10'h001, 4'b0110);
    bus.keycode    = 16'h0416;
    bus.frame_tick = 1'b1;
    Reset_n        = 1'b0;
    @(posedge Clk);
    #1;
    bus.frame_tick = 1'b0;
    chk("rsttick_kc",   32'(bus.keycode_out), 32'h0);
    chk("rsttick_x",    32'(bus.x_motion),    32'h0);
    chk("rsttick_y",    32'(bus.y_motion),    32'h0);
    chk("rsttick_held", 32'(bus.key_held),    32'h0);
    chk("rsttick_upd",  32'(bus.motion_upd),  32'h0);
    Reset_n = 1'b1;
    idle(2);

    // First ticks after reset are processed normally
    tk(16'h0416, 16'h0000, 10'h000, 10'h000, 4'b0000);
    tk(16'h0416, 16'h0416, 10'h3FF, 10'h001, 4'b0110);

    idle(3);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wasd_key_filter.md
WASD_KEY_FILTER -- requirements
Module: wasd_key_filter

Interface
REQ-001 Parameter DEBOUNCE_FRAMES, default 2: consecutive frame ticks required to accept a press or release; legal range 1..3.
REQ-002 Parameter STEP, default 10'd1: motion magnitude per axis.
REQ-003 Clk  input  1  system clock; the only clock.
REQ-004 Reset_n  input  1  reset, synchronous to Clk, active-low.
REQ-005 frame_tick  input  1  one-Clk pulse per video frame.
REQ-006 keycode  input  16  raw keycode pair from the USB host, two 8-bit slots [15:8] and [7:0].
REQ-007 keycode_out  output  16  filtered code pair {x_key, y_key} for the ball stage.
REQ-008 x_motion  output  10  two's-complement X motion: -STEP, 0 or +STEP.
REQ-009 y_motion  output  10  two's-complement Y motion: -STEP, 0 or +STEP.
REQ-010 motion_upd  output  1  one-Clk pulse when the outputs are refreshed.
REQ-011 key_held  output  4  debounced state {W,A,S,D}, bit 3 = W.

Function
REQ-012 A key is present when either keycode slot equals its code: W=8'h1A, A=8'h04, S=8'h16, D=8'h07. All other byte values, including 8'h00, shall be ignored.
REQ-013 keycode shall be sampled only in a Clk cycle where frame_tick=1; keycode changes between ticks shall have no effect.
REQ-014 Each key shall have an FSM with states IDLE, PRESS_PEND, HELD and REL_PEND, plus a 2-bit counter.
REQ-015 IDLE: if the key is present at a tick, go to PRESS_PEND with count=1, or go directly to HELD when DEBOUNCE_FRAMES=1.
REQ-016 PRESS_PEND: if present at a tick, increment the count and enter HELD when the count reaches DEBOUNCE_FRAMES; if absent at a tick, return to IDLE with count=0.
REQ-017 HELD and REL_PEND: mirror REQ-015/016 for absence, leaving HELD through REL_PEND to IDLE; if the key is present while in REL_PEND, return to HELD.
REQ-018 key_held bit = 1 exactly when the key FSM is in HELD or REL_PEND.
REQ-019 Opposing pair A/D (X axis): when only one is held, that key wins; when both are held, the key that entered HELD most recently wins.
REQ-020 The same rule as REQ-019 shall apply to the W/S pair on the Y axis.
REQ-021 If both keys of a pair enter HELD on the same tick, that axis shall be neutral until one of them releases.
REQ-022 x_key = winning X code or 8'h00; y_key = winning Y code or 8'h00; keycode_out = {x_key, y_key}, for example A+W gives 16'h041A and D alone gives 16'h0700.
REQ-023 Motion mapping: A gives x_motion=-STEP, D gives +STEP, W gives y_motion=-STEP, S gives +STEP, and a neutral axis gives 0. Negation shall be 10-bit two's complement (~STEP+1).
REQ-024 All outputs shall be registered and shall change only in the Clk cycle after a frame_tick cycle; motion_upd=1 in that same cycle only.
REQ-025 Outputs shall hold their values between updates.
REQ-026 Latency: a key first present at tick k shall appear on the outputs one Clk after tick k+DEBOUNCE_FRAMES-1.
REQ-027 A frame_tick asserted on consecutive Clk cycles shall count as separate ticks.

Reset
REQ-028 When Reset_n=0 at a Clk edge, all FSMs shall go to IDLE, all counters and last-pressed trackers shall clear, and keycode_out=16'h0000, x_motion=0, y_motion=0, motion_upd=0 and key_held=4'b0000.
REQ-029 Reset shall take priority over a coincident frame_tick; the tick shall be discarded, including one arriving mid-debounce.
REQ-030 The first tick after Reset_n returns high shall be processed normally.

Structure
REQ-031 The package key_pkg shall hold the four key-code constants, the key FSM state enum, and the 2-bit axis-winner enum (NONE, NEG, POS).
REQ-032 The sub-module key_debounce (one FSM plus counter, outputs held and a one-cycle rise pulse) shall be instantiated four times.
REQ-033 Axis arbitration and output registers shall live in the top level.

Verification
REQ-034 keycode=16'h001A held for ticks 1..2 with DEBOUNCE_FRAMES=2 -> after tick 2: keycode_out=16'h001A, y_motion=10'h3FF, x_motion=0, motion_upd pulses once per tick.
REQ-035 16'h0700 present at one tick only, then 16'h0000 -> outputs stay 0 and key_held stays 4'b0000.
REQ-036 D held, then A added (16'h0704) for 2 ticks -> x_motion=10'h3FF; then A removed for 2 ticks -> x_motion=10'h001.
REQ-037 16'h1A16 from idle for 2 ticks -> y_motion=0 and y_key=00; then S removed for 2 ticks -> y_motion=10'h3FF.
REQ-038 16'h0416 held, then Reset_n=0 coincident with a frame_tick -> all outputs 0 next cycle, with no motion_upd.
REQ-039 keycode toggled between frame ticks (16'h0007 off-tick, 16'h0000 on-tick) -> no response.
